// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port register file with write-through bypass,
// a hardwired-zero register, a hardware init sequencer and a per-register
// pending-write scoreboard for the pipeline hazard unit.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   ra1, ra2   read addresses (combinational read, zero latency)
//   rd1, rd2   read data (bypassed from same-cycle writes)
//   we3/wa3/wd3  primary write port (high priority)
//   we4/wa4/wd4  secondary write port (low priority, late/load writeback)
//   sb_set, sb_addr  mark a register as having an outstanding write
//   pend1, pend2     read register has an outstanding write
//   init_busy  init sequencer active; file unusable while high
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 32,
  parameter int ZERO_REG  = 31,
  parameter int INIT_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(DEPTH)-1:0]   ra1,
  input  logic [$clog2(DEPTH)-1:0]   ra2,
  output logic [WIDTH-1:0]           rd1,
  output logic [WIDTH-1:0]           rd2,
  input  logic                       we3,
  input  logic [$clog2(DEPTH)-1:0]   wa3,
  input  logic [WIDTH-1:0]           wd3,
  input  logic                       we4,
  input  logic [$clog2(DEPTH)-1:0]   wa4,
  input  logic [WIDTH-1:0]           wd4,
  input  logic                       sb_set,
  input  logic [$clog2(DEPTH)-1:0]   sb_addr,
  output logic                       pend1,
  output logic                       pend2,
  output logic                       init_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZA   = AW'(ZERO_REG);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_reg;
  logic [AW-1:0]    cnt_reg;
  logic [DEPTH-1:0] sb_reg;
  logic [DEPTH-1:0] sb_next;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             run;
  logic             init_wr;
  logic [WIDTH-1:0] init_val;
  logic             w3_eff;
  logic             w4_any;
  logic             w4_eff;

  assign run     = (state_reg == ST_RUN);
  assign init_wr = (state_reg == ST_INIT);

  // Writes to the zero register never land and never count as writes.
  assign w3_eff = run && we3 && (wa3 != ZA);
  assign w4_any = run && we4 && (wa4 != ZA);
  // Port 4 loses a same-address collision with port 3.
  assign w4_eff = w4_any && !(w3_eff && (wa3 == wa4));

  always_comb begin
    init_val = '0;
    if (INIT_MODE == 1 && cnt_reg != ZA) begin
      init_val = WIDTH'(cnt_reg);
    end
  end

  // ---------------------------------------------------------------------------
  // Init sequencer: walks every register once, then parks in RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else if (state_reg == ST_INIT) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg == LAST) begin
        state_reg <= ST_RUN;
      end
    end
  end

  assign init_busy = init_wr;

  // ---------------------------------------------------------------------------
  // Storage. The zero register has no flop; the rest are not reset because the
  // init sequencer gives them their defined contents.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign mem_q[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] q_reg;
        always_ff @(posedge clk) begin
          if (init_wr) begin
            if (cnt_reg == AW'(gi)) q_reg <= init_val;
          end else if (w3_eff && wa3 == AW'(gi)) begin
            q_reg <= wd3;
          end else if (w4_eff && wa4 == AW'(gi)) begin
            q_reg <= wd4;
          end
        end
        assign mem_q[gi] = q_reg;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read ports with write-through bypass: zero reg, then port 3, then port 4.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd1 = '0;
    if (run && ra1 != ZA) begin
      if (w3_eff && wa3 == ra1)      rd1 = wd3;
      else if (w4_any && wa4 == ra1) rd1 = wd4;
      else                           rd1 = mem_q[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (run && ra2 != ZA) begin
      if (w3_eff && wa3 == ra2)      rd2 = wd3;
      else if (w4_any && wa4 == ra2) rd2 = wd4;
      else                           rd2 = mem_q[ra2];
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard. Clears come first so that a same-cycle set
  // (a newly issued producer) wins over a completing write.
  // ---------------------------------------------------------------------------
  always_comb begin
    sb_next = sb_reg;
    if (w3_eff) sb_next[wa3] = 1'b0;
    if (w4_any) sb_next[wa4] = 1'b0;
    if (sb_set && sb_addr != ZA) sb_next[sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_reg <= '0;
    end else if (run) begin
      sb_reg <= sb_next;
    end
  end

  // Data forwarded this cycle is not pending, matching the bypass.
  assign pend1 = run && sb_reg[ra1] && !(w3_eff && wa3 == ra1) && !(w4_any && wa4 == ra1);
  assign pend2 = run && sb_reg[ra2] && !(w3_eff && wa3 == ra2) && !(w4_any && wa4 == ra2);

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    logic [4:0]  ra1, ra2, wa3, wa4, sb_addr;
    logic        we3, we4, sb_set;
    logic [63:0] wd3, wd4;
    logic [63:0] rd1, rd2, c_rd1, c_rd2;
    logic        pend1, pend2, init_busy, c_pend1, c_pend2, c_busy;

    logic [3:0]  b_ra1, b_ra2, b_wa3, b_wa4, b_sb_addr;
    logic        b_we3, b_we4, b_sb_set;
    logic [31:0] b_wd3, b_wd4, b_rd1, b_rd2;
    logic        b_pend1, b_pend2, b_busy;

    regfile_mp u_a (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend1(pend1), .pend2(pend2),
        .init_busy(init_busy)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(16), .ZERO_REG(0), .INIT_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
        .we3(b_we3), .wa3(b_wa3), .wd3(b_wd3), .we4(b_we4), .wa4(b_wa4), .wd4(b_wd4),
        .sb_set(b_sb_set), .sb_addr(b_sb_addr), .pend1(b_pend1), .pend2(b_pend2),
        .init_busy(b_busy)
    );

    regfile_mp #(.INIT_MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(c_rd1), .rd2(c_rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend1(c_pend1), .pend2(c_pend2),
        .init_busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_RD1 = 0, S_RD2 = 1, S_PEND1 = 2, S_PEND2 = 3, S_BUSY = 4;
    localparam int S_BRD1 = 5, S_BRD2 = 6, S_BBUSY = 7, S_CRD1 = 8, S_CBUSY = 9;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                S_RD1:   act = rd1;
                S_RD2:   act = rd2;
                S_PEND1: act = {63'd0, pend1};
                S_PEND2: act = {63'd0, pend2};
                S_BUSY:  act = {63'd0, init_busy};
                S_BRD1:  act = {32'd0, b_rd1};
                S_BRD2:  act = {32'd0, b_rd2};
                S_BBUSY: act = {63'd0, b_busy};
                S_CRD1:  act = c_rd1;
                S_CBUSY: act = {63'd0, c_busy};
                default: act = 'x;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
            end else begin
                $display("ok   %s: %0h", e.name, act);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [63:0] v, input string n);
        q.push_back('{sel, v, n});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we3 = 0; we4 = 0; sb_set = 0;
        b_we3 = 0; b_we4 = 0; b_sb_set = 0;
    endtask

    task automatic check_init(input string tag);
        for (int k = 0; k < 32; k++) begin
            expect_val(S_BUSY, 64'd1, $sformatf("%s busy_a[%0d]", tag, k));
            expect_val(S_CBUSY, 64'd1, $sformatf("%s busy_c[%0d]", tag, k));
            expect_val(S_BBUSY, (k < 16) ? 64'd1 : 64'd0, $sformatf("%s busy_b[%0d]", tag, k));
            if (k == 3) begin
                expect_val(S_RD1, 64'd0, $sformatf("%s rd1 forced 0 in init", tag));
                expect_val(S_PEND1, 64'd0, $sformatf("%s pend1 forced 0 in init", tag));
            end
            step();
        end
        expect_val(S_BUSY, 64'd0, $sformatf("%s busy_a done", tag));
        expect_val(S_CBUSY, 64'd0, $sformatf("%s busy_c done", tag));
    endtask

    task automatic wait_init_done(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: init_busy still high after %0d cycles", tag, max_cycles);
        end else begin
            $display("ok   %s: init done after %0d cycles", tag, n);
        end
    endtask

    initial begin
        rst_n = 0;
        ra1 = 5; ra2 = 31; wa3 = 0; wa4 = 0; sb_addr = 0; wd3 = 0; wd4 = 0;
        b_ra1 = 0; b_ra2 = 15; b_wa3 = 0; b_wa4 = 0; b_sb_addr = 0; b_wd3 = 0; b_wd4 = 0;
        idle_writes();
        #1;
        checks++;
        if (init_busy !== 1'b1 || rd1 !== 64'd0 || rd2 !== 64'd0 ||
            pend1 !== 1'b0 || pend2 !== 1'b0) begin
            errors++;
            $display("FAIL reset state: busy=%b rd1=%0h rd2=%0h pend1=%b pend2=%b",
                     init_busy, rd1, rd2, pend1, pend2);
        end else begin
            $display("ok   reset state direct");
        end
        expect_val(S_BUSY, 64'd1, "reset busy");
        expect_val(S_RD1, 64'd0, "reset rd1");
        expect_val(S_RD2, 64'd0, "reset rd2");
        expect_val(S_PEND1, 64'd0, "reset pend1");
        expect_val(S_PEND2, 64'd0, "reset pend2");
        step();
        step();
        rst_n = 1;

        check_init("init1");
        expect_val(S_RD1, 64'd5, "post-init rd1 reg5");
        expect_val(S_RD2, 64'd0, "post-init rd2 zero reg");
        expect_val(S_CRD1, 64'd0, "INIT_MODE0 rd1 reg5");
        expect_val(S_BBUSY, 64'd0, "B busy done");
        expect_val(S_BRD1, 64'd0, "B reg0 zero");
        expect_val(S_BRD2, 64'd15, "B reg15");
        step();

        we3 = 1; wa3 = 3; wd3 = 64'hDEAD; ra1 = 3;
        expect_val(S_RD1, 64'hDEAD, "bypass p3 rd1");
        step();
        we3 = 0;
        expect_val(S_RD1, 64'hDEAD, "array reg3");
        step();

        we3 = 1; wa3 = 9; wd3 = 64'h11; we4 = 1; wa4 = 9; wd4 = 64'h22; ra2 = 9;
        expect_val(S_RD2, 64'h11, "collision bypass rd2");
        step();
        idle_writes(); ra1 = 9;
        expect_val(S_RD2, 64'h11, "collision array rd2");
        expect_val(S_RD1, 64'h11, "collision array rd1");
        step();

        we3 = 1; wa3 = 31; wd3 = 64'hFF; ra1 = 31;
        expect_val(S_RD1, 64'd0, "zero reg bypass");
        step();
        we3 = 0;
        expect_val(S_RD1, 64'd0, "zero reg array");
        step();

        we4 = 1; wa4 = 20; wd4 = 64'h2020; ra1 = 20; ra2 = 20;
        expect_val(S_RD1, 64'h2020, "p4 bypass rd1");
        expect_val(S_RD2, 64'h2020, "p4 bypass rd2");
        step();
        we3 = 1; wa3 = 21; wd3 = 64'h2121; we4 = 1; wa4 = 22; wd4 = 64'h2222; ra1 = 21; ra2 = 22;
        expect_val(S_RD1, 64'h2121, "split bypass rd1 p3");
        expect_val(S_RD2, 64'h2222, "split bypass rd2 p4");
        step();
        idle_writes(); ra1 = 20;
        expect_val(S_RD1, 64'h2020, "array reg20");
        expect_val(S_RD2, 64'h2222, "array reg22");
        step();

        sb_set = 1; sb_addr = 7; ra1 = 7;
        expect_val(S_PEND1, 64'd0, "sb set same cycle");
        step();
        sb_set = 0;
        expect_val(S_PEND1, 64'd1, "sb pend1 next cycle");
        step();
        we4 = 1; wa4 = 7; wd4 = 64'h77;
        expect_val(S_PEND1, 64'd0, "sb clear same cycle");
        expect_val(S_RD1, 64'h77, "sb clear bypass");
        step();
        we4 = 0;
        expect_val(S_PEND1, 64'd0, "sb stays clear");
        expect_val(S_RD1, 64'h77, "reg7 array");
        step();

        sb_set = 1; sb_addr = 12; we3 = 1; wa3 = 12; wd3 = 64'hC; ra2 = 12;
        expect_val(S_PEND2, 64'd0, "set+write same cycle pend2");
        step();
        idle_writes();
        expect_val(S_PEND2, 64'd1, "set wins over write");
        expect_val(S_RD2, 64'hC, "reg12 array");
        step();
        we3 = 1; wa3 = 12; wd3 = 64'hCC;
        expect_val(S_PEND2, 64'd0, "pend2 masked by write");
        step();
        we3 = 0;
        expect_val(S_PEND2, 64'd0, "pend2 cleared");
        step();

        sb_set = 1; sb_addr = 31; ra1 = 31;
        step();
        sb_set = 0;
        expect_val(S_PEND1, 64'd0, "sb zero reg ignored");
        step();

        b_we3 = 1; b_wa3 = 0; b_wd3 = 32'hAB; b_ra1 = 0;
        expect_val(S_BRD1, 64'd0, "B zero reg bypass");
        step();
        b_we3 = 0;
        expect_val(S_BRD1, 64'd0, "B zero reg array");
        expect_val(S_BRD2, 64'd15, "B reg15 again");
        step();

        rst_n = 0;
        step();
        rst_n = 1;
        ra1 = 5;
        for (int k = 0; k < 10; k++) step();
        rst_n = 0;
        #1;
        expect_val(S_BUSY, 64'd1, "mid-init reset busy");
        expect_val(S_RD1, 64'd0, "mid-init reset rd1");
        step();
        step();
        rst_n = 1;
        we3 = 1; wa3 = 4; wd3 = 64'hBAD; sb_set = 1; sb_addr = 6; ra1 = 3; ra2 = 6;
        fork
            check_init("init2");
            wait_init_done(40, "init2 wait");
        join
        idle_writes(); ra1 = 4;
        expect_val(S_RD1, 64'd4, "init ignores we3 reg4");
        expect_val(S_PEND2, 64'd0, "init ignores sb_set");
        step();
        expect_val(S_PEND2, 64'd0, "sb_set ignored next cycle");
        ra1 = 3;
        expect_val(S_RD1, 64'd3, "reg3 reinitialised");
        step();

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
